sha256_target_checker: RTL and testbench

- Downstream consumer of the SHA-256 core's output for the bitcoin-hash flow.
- After the core writes its 8-word digest (h0 first, h0 = most significant) to memory, this block reads that digest and an 8-word difficulty target from the same shared memory.
- It decides whether digest <= target (unsigned 256-bit), counts the digest's leading zero bits, and writes a one-word result record back to memory.

---
 rtl/sha256_target_checker.sv | 131 +++++++++++++
 tb/tb_sha256_target_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_target_checker.sv
// rtl/sha256_target_checker.sv - reads digest and target from memory, compares them, writes a result record
module sha256_target_checker #(
  parameter int HASH_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] target_addr,
  input  logic [15:0] result_addr,
  output logic        done,
  output logic        hash_ok,
  output logic [8:0]  leading_zeros,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int IDX_W = $clog2(2 * HASH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * HASH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP, WRITE} state_t;
  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

  state_t           state;
  cmp_t             cmp, cmp_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [15:0]      hash_base, target_base, result_base;
  logic [31:0]      hw;
  logic [8:0]       lz, lz_next;
  logic             lz_done, lz_done_next, ok_next;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = 6'(31 - i);
    return n;
  endfunction

  // Even indices fetch digest words, odd indices the matching target word.
  function automatic logic [15:0] word_addr(input logic [IDX_W-1:0] i,
                                            input logic [15:0] hbase,
                                            input logic [15:0] tbase);
    return (i[0] ? tbase : hbase) + 16'(i >> 1);
  endfunction

  assign mem_clk  = clk;
  assign done     = (state == IDLE);
  assign idx_next = idx + IDX_W'(1);

  always_comb begin
    cmp_next     = cmp;
    lz_next      = lz;
    lz_done_next = lz_done;
    if (state == CAP) begin
      if (!idx[0]) begin
        if (!lz_done) begin
          lz_next      = lz + 9'(clz32(mem_read_data));
          lz_done_next = |mem_read_data;
        end
      end else if (cmp == CMP_EQ) begin
        if (hw < mem_read_data)      cmp_next = CMP_LT;
        else if (hw > mem_read_data) cmp_next = CMP_GT;
      end
    end
    ok_next = (cmp_next != CMP_GT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cmp            <= CMP_EQ;
      idx            <= '0;
      hash_base      <= '0;
      target_base    <= '0;
      result_base    <= '0;
      hw             <= '0;
      lz             <= '0;
      lz_done        <= 1'b0;
      hash_ok        <= 1'b0;
      leading_zeros  <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            hash_base   <= hash_addr;
            target_base <= target_addr;
            result_base <= result_addr;
            idx         <= '0;
            cmp         <= CMP_EQ;
            lz          <= '0;
            lz_done     <= 1'b0;
            mem_addr    <= hash_addr;
            state       <= REQ;
          end
        end
        REQ: state <= CAP;
        CAP: begin
          if (!idx[0]) hw <= mem_read_data;
          cmp     <= cmp_next;
          lz      <= lz_next;
          lz_done <= lz_done_next;
          idx     <= idx_next;
          // The record is assembled here so it is on the bus for the whole WRITE cycle.
          if (idx == LAST_IDX) begin
            mem_we         <= 1'b1;
            mem_addr       <= result_base;
            mem_write_data <= {ok_next, 22'b0, lz_next};
            state          <= WRITE;
          end else begin
            mem_addr <= word_addr(idx_next, hash_base, target_base);
            state    <= REQ;
          end
        end
        WRITE: begin
          mem_we        <= 1'b0;
          hash_ok       <= (cmp != CMP_GT);
          leading_zeros <= lz;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_target_checker.sv
// tb/tb_sha256_target_checker.sv - self-checking bench for sha256_target_checker
module tb_sha256_target_checker;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_addr, target_addr, result_addr;
  logic        done, hash_ok, mem_clk, mem_we;
  logic [8:0]  leading_zeros;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  sha256_target_checker #(.HASH_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .hash_addr(hash_addr), .target_addr(target_addr), .result_addr(result_addr),
    .done(done), .hash_ok(hash_ok), .leading_zeros(leading_zeros),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int          wr_count;
  logic [15:0] wr_addr;
  logic [15:0] trace[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (!done && !mem_we) trace.push_back(mem_addr);
    if (mem_we) begin
      mem[mem_addr] = mem_write_data;
      wr_count = wr_count + 1;
      wr_addr = mem_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] ha, input logic [15:0] ta,
                      input logic [255:0] h, input logic [255:0] t);
    for (int i = 0; i < 8; i++) mem[16'(ha + 16'(i))] = h[255 - 32*i -: 32];
    for (int i = 0; i < 8; i++) mem[16'(ta + 16'(i))] = t[255 - 32*i -: 32];
  endtask

  // Reference: treat digest and target as 256-bit numbers taken from the memory image.
  task automatic model(input logic [15:0] ha, input logic [15:0] ta,
                       output logic ok, output logic [8:0] lz);
    logic [255:0] hv, tv;
    hv = '0; tv = '0;
    for (int i = 0; i < 8; i++) begin
      hv = {hv[223:0], mem[16'(ha + 16'(i))]};
      tv = {tv[223:0], mem[16'(ta + 16'(i))]};
    end
    ok = (hv <= tv);
    lz = 9'd256;
    for (int b = 0; b < 256; b++) if (hv[b]) lz = 9'(255 - b);
  endtask

  task automatic do_run(input logic [15:0] ha, input logic [15:0] ta, input logic [15:0] ra,
                        input int extra, output int n);
    wr_count = 0;
    trace.delete();
    @(negedge clk);
    hash_addr = ha; target_addr = ta; result_addr = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == extra);
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] ha, input logic [15:0] ta,
                               input logic [15:0] ra, input logic exp_ok, input logic [8:0] exp_lz,
                               input int extra);
    int n;
    do_run(ha, ta, ra, extra, n);
    chk({tag, " latency"}, n, 33);
    chk({tag, " hash_ok"}, {31'b0, hash_ok}, {31'b0, exp_ok});
    chk({tag, " leading_zeros"}, {23'b0, leading_zeros}, {23'b0, exp_lz});
    chk({tag, " record"}, mem[ra], {exp_ok, 22'b0, exp_lz});
    chk({tag, " write count"}, wr_count, 1);
    chk({tag, " write addr"}, {16'b0, wr_addr}, {16'b0, ra});
    chk({tag, " read count"}, trace.size(), 32);
    if (trace.size() == 32)
      for (int k = 0; k < 16; k++)
        chk({tag, " read addr"}, {16'b0, trace[2*k]},
            {16'b0, (k % 2 == 1) ? 16'(ta + 16'(k / 2)) : 16'(ha + 16'(k / 2))});
    repeat (3) @(negedge clk);
    chk({tag, " idle after"}, {31'b0, done}, 32'd1);
  endtask

  typedef struct packed {
    logic [15:0]  ha, ta, ra;
    logic [255:0] h, t;
    logic         exp_ok;
    logic [8:0]   exp_lz;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [31:0] rword();
    return $urandom >> $urandom_range(0, 32);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] h, t;
    logic [15:0]  ha, ta, ra;
    logic         eok;
    logic [8:0]   elz;
    int           n;

    vecs[0] = '{16'h0010, 16'h0020, 16'h0030, 256'h0,
                {32'h0, 32'h0000FFFF, 192'h0}, 1'b1, 9'd256};
    vecs[1] = '{16'h0040, 16'h0040, 16'h0050, {32'h00000ABC, {7{32'hFFFFFFFF}}},
                {32'h00000ABC, {7{32'hFFFFFFFF}}}, 1'b1, 9'd20};
    vecs[2] = '{16'h0060, 16'h0070, 16'h0080, {32'h1, {7{32'hFFFFFFFF}}},
                {32'h2, 224'h0}, 1'b1, 9'd31};
    vecs[3] = '{16'h0090, 16'h00A0, 16'h00B0, {{7{32'h12345678}}, 32'h10},
                {{7{32'h12345678}}, 32'h0F}, 1'b0, 9'd3};

    reset_n = 1'b0; start = 1'b0;
    hash_addr = '0; target_addr = '0; result_addr = '0;
    wr_count = 0;
    repeat (3) @(negedge clk);
    chk("reset done", {31'b0, done}, 32'd1);
    chk("reset hash_ok", {31'b0, hash_ok}, 32'd0);
    chk("reset leading_zeros", {23'b0, leading_zeros}, 32'd0);
    chk("reset mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("reset mem_write_data", mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].ha, vecs[v].ta, vecs[v].h, vecs[v].t);
      run_and_check($sformatf("vec%0d", v), vecs[v].ha, vecs[v].ta, vecs[v].ra,
                    vecs[v].exp_ok, vecs[v].exp_lz, -1);
    end

    // Reset while capturing target word 4 (idx 9): abort, no write, outputs cleared.
    mem[16'h0300] = 32'hDEADBEEF;
    load(16'h0200, 16'h0210, {8{32'h0000_00F0}}, {8{32'h0000_0100}});
    wr_count = 0;
    @(negedge clk);
    hash_addr = 16'h0200; target_addr = 16'h0210; result_addr = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset done", {31'b0, done}, 32'd1);
    chk("midreset hash_ok", {31'b0, hash_ok}, 32'd0);
    chk("midreset leading_zeros", {23'b0, leading_zeros}, 32'd0);
    chk("midreset mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset no write", wr_count, 0);
    chk("midreset record untouched", mem[16'h0300], 32'hDEADBEEF);
    chk("midreset stays idle", {31'b0, done}, 32'd1);
    run_and_check("after reset", 16'h0200, 16'h0210, 16'h0300, 1'b1, 9'd24, -1);

    // Address wrap, then stray start pulses mid-run and on the cycle done rises.
    h = {8{32'h0F00_0000}}; t = {8{32'h0E00_0000}};
    load(16'hFFFC, 16'h0100, h, t);
    run_and_check("wrap", 16'hFFFC, 16'h0100, 16'h0400, 1'b0, 9'd4, -1);
    run_and_check("restart mid", 16'hFFFC, 16'h0100, 16'h0400, 1'b0, 9'd4, 10);
    run_and_check("restart at done", 16'hFFFC, 16'h0100, 16'h0400, 1'b0, 9'd4, 32);

    for (int r = 0; r < 25; r++) begin
      int zw, mode, j;
      ha = 16'($urandom);
      ta = ($urandom_range(0, 5) == 0) ? ha : 16'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'(ha + 16'($urandom_range(0, 7))) : 16'($urandom);
      zw = $urandom_range(0, 8);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) begin
        h[255 - 32*i -: 32] = (i < zw) ? 32'h0 : rword();
        t[255 - 32*i -: 32] = rword();
      end
      if (mode != 0) t = h;
      if (mode == 2) begin
        j = $urandom_range(0, 7);
        t[255 - 32*j -: 32] = h[255 - 32*j -: 32] + (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFFFFFF);
      end
      load(ha, ta, h, t);
      model(ha, ta, eok, elz);
      run_and_check($sformatf("rand%0d", r), ha, ta, ra, eok, elz, -1);
    end

    n = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
